apb_protocol_monitor: RTL and testbench



---
 rtl/apb_protocol_monitor_if.sv | 27 ++
 rtl/apb_protocol_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_apb_protocol_monitor.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_protocol_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_protocol_monitor_if
//  Description : APB bus bundle with master, slave and passive-monitor views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_protocol_monitor_if #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int NUM_SEL = 4
);
    logic [NUM_SEL-1:0] psel;
    logic               penable;
    logic               pwrite;
    logic [ADDR_W-1:0]  paddr;
    logic [DATA_W-1:0]  pwdata;
    logic               pready;
    logic               pslverr;

    modport master  (output psel, penable, pwrite, paddr, pwdata,
                     input  pready, pslverr);
    modport slave   (input  psel, penable, pwrite, paddr, pwdata,
                     output pready, pslverr);
    modport monitor (input  psel, penable, pwrite, paddr, pwdata,
                            pready, pslverr);
endinterface
`default_nettype wire

// File: rtl/apb_protocol_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : apb_protocol_monitor
//  Description : Passive APB checker: tracks SETUP/ACCESS, flags rule
//                violations, counts transfers/errors, captures first error.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_protocol_monitor #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int NUM_SEL = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    chk_en,
    input  logic                    err_clr,
    apb_protocol_monitor_if.monitor bus,
    output logic [6:0]              err_vec,
    output logic                    err_pulse,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [CNT_W-1:0]        xfer_cnt,
    output logic [CNT_W-1:0]        slverr_cnt,
    output logic                    first_err_valid,
    output logic [2:0]              first_err_id,
    output logic [ADDR_W-1:0]       first_err_addr,
    output logic                    busy
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0]        c_ST_IDLE   = 2'd0;
    localparam logic [1:0]        c_ST_SETUP  = 2'd1;
    localparam logic [1:0]        c_ST_ACCESS = 2'd2;
    localparam logic [WAIT_W-1:0] c_TIMEOUT   = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

    logic [NUM_SEL-1:0] w_psel;
    logic               w_penable, w_pwrite, w_pready, w_pslverr;
    logic [ADDR_W-1:0]  w_paddr;
    logic [DATA_W-1:0]  w_pwdata;

    assign w_psel    = bus.psel;
    assign w_penable = bus.penable;
    assign w_pwrite  = bus.pwrite;
    assign w_paddr   = bus.paddr;
    assign w_pwdata  = bus.pwdata;
    assign w_pready  = bus.pready;
    assign w_pslverr = bus.pslverr;

    logic [1:0]         r_state, w_state_nxt;
    logic [WAIT_W-1:0]  r_wait, w_wait_nxt;
    logic [NUM_SEL-1:0] r_cap_sel;
    logic [ADDR_W-1:0]  r_cap_addr;
    logic               r_cap_write;
    logic [DATA_W-1:0]  r_cap_wdata;
    logic               r_done_d;

    logic               w_sel_any, w_mismatch, w_capture, w_done, w_viol;
    logic [6:0]         w_rule;
    logic [2:0]         w_first_id;

    logic [6:0]         r_err_vec, w_vec_base;
    logic [CNT_W-1:0]   r_err_cnt, w_cnt_base, r_xfer_cnt, r_slverr_cnt;
    logic               r_err_pulse, r_first_valid, w_fv_base;
    logic [2:0]         r_first_id;
    logic [ADDR_W-1:0]  r_first_addr;

    assign w_sel_any  = |w_psel;
    assign w_mismatch = (w_psel != r_cap_sel) || (w_paddr != r_cap_addr) ||
                        (w_pwrite != r_cap_write) ||
                        (w_pwrite && (w_pwdata != r_cap_wdata));

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        w_rule      = '0;
        w_rule[2]   = r_done_d && w_penable;
        w_rule[4]   = (w_psel & (w_psel - NUM_SEL'(1))) != '0;
        w_rule[6]   = w_penable && !w_sel_any && !r_done_d;
        case (r_state)
            c_ST_IDLE: begin
                if (w_sel_any) begin
                    w_rule[0]   = w_penable;
                    w_capture   = 1'b1;
                    w_state_nxt = c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                if ((w_psel == r_cap_sel) && w_penable) begin
                    w_rule[3] = w_mismatch;
                    if (w_pready) begin
                        w_done      = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                        w_wait_nxt  = '0;
                    end else if (c_TIMEOUT == WAIT_W'(1)) begin
                        w_rule[5]   = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                        w_wait_nxt  = '0;
                    end else begin
                        w_state_nxt = c_ST_ACCESS;
                        w_wait_nxt  = WAIT_W'(1);
                    end
                end else if (!w_sel_any) begin
                    w_rule[1]   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_rule[1]   = 1'b1;
                    w_capture   = 1'b1;
                end
            end
            c_ST_ACCESS: begin
                // An early psel drop is already caught by the mismatch term.
                w_rule[3] = w_mismatch;
                if (!w_sel_any) begin
                    w_state_nxt = c_ST_IDLE;
                    w_wait_nxt  = '0;
                end else if (w_pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                    w_wait_nxt  = '0;
                end else if ((r_wait + WAIT_W'(1)) == c_TIMEOUT) begin
                    w_rule[5]   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt  = r_wait + WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_wait_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_first_id = '0;
        for (int i = 6; i >= 0; i--) begin
            if (w_rule[i]) w_first_id = 3'(i);
        end
    end

    assign w_viol     = chk_en && (w_rule != '0);
    assign w_vec_base = err_clr ? '0 : r_err_vec;
    assign w_cnt_base = err_clr ? '0 : r_err_cnt;
    assign w_fv_base  = err_clr ? 1'b0 : r_first_valid;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wait        <= '0;
            r_cap_sel     <= '0;
            r_cap_addr    <= '0;
            r_cap_write   <= 1'b0;
            r_cap_wdata   <= '0;
            r_done_d      <= 1'b0;
            r_err_vec     <= '0;
            r_err_pulse   <= 1'b0;
            r_err_cnt     <= '0;
            r_xfer_cnt    <= '0;
            r_slverr_cnt  <= '0;
            r_first_valid <= 1'b0;
            r_first_id    <= '0;
            r_first_addr  <= '0;
        end else begin
            r_wait   <= w_wait_nxt;
            r_done_d <= w_done;
            if (w_capture) begin
                r_cap_sel   <= w_psel;
                r_cap_addr  <= w_paddr;
                r_cap_write <= w_pwrite;
                r_cap_wdata <= w_pwdata;
            end
            if (w_done) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
                if (w_pslverr && (r_slverr_cnt != c_CNT_MAX)) begin
                    r_slverr_cnt <= r_slverr_cnt + CNT_W'(1);
                end
            end
            // err_clr and a same-cycle violation: record on top of cleared state.
            r_err_pulse <= w_viol;
            r_err_vec   <= w_vec_base | (chk_en ? w_rule : 7'd0);
            if (w_viol && (w_cnt_base != c_CNT_MAX)) begin
                r_err_cnt <= w_cnt_base + CNT_W'(1);
            end else begin
                r_err_cnt <= w_cnt_base;
            end
            if (w_viol && !w_fv_base) begin
                r_first_valid <= 1'b1;
                r_first_id    <= w_first_id;
                r_first_addr  <= w_paddr;
            end else if (err_clr) begin
                r_first_valid <= 1'b0;
                r_first_id    <= '0;
                r_first_addr  <= '0;
            end
        end
    end

    assign err_vec         = r_err_vec;
    assign err_pulse       = r_err_pulse;
    assign err_cnt         = r_err_cnt;
    assign xfer_cnt        = r_xfer_cnt;
    assign slverr_cnt      = r_slverr_cnt;
    assign first_err_valid = r_first_valid;
    assign first_err_id    = r_first_id;
    assign first_err_addr  = r_first_addr;
    assign busy            = (r_state != c_ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_apb_protocol_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_protocol_monitor
//  Description : Directed stimulus with a per-cycle reference model check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_protocol_monitor;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int NUM_SEL = 4;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic pclk = 1'b0;
    logic preset, chk_en, err_clr;
    logic [6:0]        err_vec;
    logic              err_pulse, first_err_valid, busy;
    logic [CNT_W-1:0]  err_cnt, xfer_cnt, slverr_cnt;
    logic [2:0]        first_err_id;
    logic [ADDR_W-1:0] first_err_addr;

    int n_vec = 0;
    int n_err = 0;

    apb_protocol_monitor_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SEL(NUM_SEL)) bus ();

    apb_protocol_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SEL(NUM_SEL),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .pclk(pclk), .preset(preset), .chk_en(chk_en), .err_clr(err_clr),
        .bus(bus),
        .err_vec(err_vec), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .xfer_cnt(xfer_cnt), .slverr_cnt(slverr_cnt),
        .first_err_valid(first_err_valid), .first_err_id(first_err_id),
        .first_err_addr(first_err_addr), .busy(busy)
    );

    always #5 pclk = ~pclk;

    // Reference model: an in-flight transfer record plus wait-cycle count.
    bit          t_active = 0;
    int          t_waits  = 0;
    bit          t_setup  = 0;
    logic [3:0]  t_sel    = '0;
    logic [15:0] t_addr   = '0;
    bit          t_wr     = 0;
    logic [31:0] t_data   = '0;
    bit          m_done_prev = 0;
    int          m_xfer = 0, m_slv = 0, m_ecnt = 0, m_fid = 0;
    logic [6:0]  m_vec  = '0;
    logic [15:0] m_faddr = '0;
    bit          m_pulse = 0, m_fv = 0, m_busy = 0;

    always @(posedge pclk) begin
        logic [6:0] r;
        bit done, sel_any, diff;
        if (preset) begin
            t_active = 0; t_waits = 0; t_setup = 0; m_done_prev = 0;
            t_sel = '0; t_addr = '0; t_wr = 0; t_data = '0;
            m_xfer = 0; m_slv = 0; m_ecnt = 0; m_fid = 0; m_vec = '0;
            m_faddr = '0; m_pulse = 0; m_fv = 0; m_busy = 0;
        end else begin
            r = '0;
            done = 0;
            sel_any = (bus.psel != 4'd0);
            diff = (bus.psel != t_sel) || (bus.paddr != t_addr) ||
                   (bus.pwrite != t_wr) || (bus.pwrite && (bus.pwdata != t_data));
            if ($countones(bus.psel) > 1) r[4] = 1'b1;
            if (bus.penable && m_done_prev) r[2] = 1'b1;
            if (bus.penable && !sel_any && !m_done_prev) r[6] = 1'b1;
            if (!t_active) begin
                if (sel_any) begin
                    r[0] = bus.penable;
                    t_active = 1; t_setup = 1; t_waits = 0;
                    t_sel = bus.psel; t_addr = bus.paddr; t_wr = bus.pwrite; t_data = bus.pwdata;
                end
            end else if (t_setup) begin
                if (bus.penable && (bus.psel == t_sel)) begin
                    r[3] = diff;
                    t_setup = 0;
                    if (bus.pready) begin
                        done = 1; t_active = 0;
                    end else begin
                        t_waits = 1;
                        if (t_waits >= TIMEOUT) begin r[5] = 1'b1; t_active = 0; end
                    end
                end else begin
                    r[1] = 1'b1;
                    if (sel_any) begin
                        t_sel = bus.psel; t_addr = bus.paddr; t_wr = bus.pwrite; t_data = bus.pwdata;
                    end else begin
                        t_active = 0;
                    end
                end
            end else begin
                r[3] = diff;
                if (!sel_any) t_active = 0;
                else if (bus.pready) begin done = 1; t_active = 0; end
                else begin
                    t_waits++;
                    if (t_waits >= TIMEOUT) begin r[5] = 1'b1; t_active = 0; end
                end
            end
            if (done) begin
                m_xfer = (m_xfer + 1) % (CMAX + 1);
                if (bus.pslverr && m_slv < CMAX) m_slv++;
            end
            m_done_prev = done;
            if (err_clr) begin
                m_vec = '0; m_ecnt = 0; m_fv = 0; m_fid = 0; m_faddr = '0;
            end
            m_pulse = chk_en && (r != 7'd0);
            if (m_pulse) begin
                m_vec = m_vec | r;
                if (m_ecnt < CMAX) m_ecnt++;
                if (!m_fv) begin
                    m_fv = 1;
                    m_faddr = bus.paddr;
                    for (int i = 6; i >= 0; i--) if (r[i]) m_fid = i;
                end
            end
            m_busy = t_active;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        chk("err_vec",         32'(err_vec),         32'(m_vec));
        chk("err_pulse",       32'(err_pulse),       32'(m_pulse));
        chk("err_cnt",         32'(err_cnt),         32'(m_ecnt));
        chk("xfer_cnt",        32'(xfer_cnt),        32'(m_xfer));
        chk("slverr_cnt",      32'(slverr_cnt),      32'(m_slv));
        chk("first_err_valid", 32'(first_err_valid), 32'(m_fv));
        chk("first_err_id",    32'(first_err_id),    32'(m_fid));
        chk("first_err_addr",  32'(first_err_addr),  32'(m_faddr));
        chk("busy",            32'(busy),            32'(m_busy));
    end

    task automatic cyc(input logic [3:0] s, input logic e, input logic w,
                       input logic [15:0] a, input logic [31:0] d, input logic rdy);
        bus.psel = s; bus.penable = e; bus.pwrite = w;
        bus.paddr = a; bus.pwdata = d; bus.pready = rdy;
        @(posedge pclk);
        @(negedge pclk);
    endtask

    initial begin
        preset = 1'b1; chk_en = 1'b1; err_clr = 1'b0; bus.pslverr = 1'b0;
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        chk("lit_reset_err_vec", 32'(err_vec), 32'h0);
        chk("lit_reset_busy",    32'(busy),    32'h0);
        preset = 1'b0;

        // legal write with two waits, then back-to-back read
        cyc(4'h2, 0, 1, 16'h0040, 32'hDEADBEEF, 0);
        cyc(4'h2, 1, 1, 16'h0040, 32'hDEADBEEF, 0);
        cyc(4'h2, 1, 1, 16'h0040, 32'hDEADBEEF, 0);
        cyc(4'h2, 1, 1, 16'h0040, 32'hDEADBEEF, 1);
        cyc(4'h2, 0, 0, 16'h0044, 32'h0, 0);
        cyc(4'h2, 1, 0, 16'h0044, 32'h0, 1);
        chk("lit_t1_xfer_cnt", 32'(xfer_cnt), 32'd2);
        chk("lit_t1_err_vec",  32'(err_vec),  32'h0);
        chk("lit_t1_err_cnt",  32'(err_cnt),  32'd0);
        chk("lit_t1_busy",     32'(busy),     32'd0);
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);

        // setup cycle with penable high
        cyc(4'h1, 1, 0, 16'h0010, 32'h0, 0);
        chk("lit_t2_err_vec",   32'(err_vec),        32'h01);
        chk("lit_t2_first_id",  32'(first_err_id),   32'd0);
        chk("lit_t2_first_adr", 32'(first_err_addr), 32'h0010);
        chk("lit_t2_pulse_hi",  32'(err_pulse),      32'd1);
        cyc(4'h1, 1, 0, 16'h0010, 32'h0, 1);
        chk("lit_t2_pulse_lo",  32'(err_pulse),      32'd0);
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        err_clr = 1'b1;
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        err_clr = 1'b0;

        // address change in ACCESS, then a two-hot psel transfer
        cyc(4'h1, 0, 1, 16'h0020, 32'h11, 0);
        cyc(4'h1, 1, 1, 16'h0020, 32'h11, 0);
        cyc(4'h1, 1, 1, 16'h0024, 32'h11, 1);
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        cyc(4'h3, 0, 0, 16'h0030, 32'h0, 0);
        cyc(4'h3, 1, 0, 16'h0030, 32'h0, 1);
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        chk("lit_t3_err_vec",   32'(err_vec),        32'h18);
        chk("lit_t3_err_cnt",   32'(err_cnt),        32'd3);
        chk("lit_t3_first_id",  32'(first_err_id),   32'd3);
        chk("lit_t3_first_adr", 32'(first_err_addr), 32'h0024);
        err_clr = 1'b1;
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        err_clr = 1'b0;

        // wait-state timeout on the 4th wait cycle
        cyc(4'h4, 0, 0, 16'h0050, 32'h0, 0);
        cyc(4'h4, 1, 0, 16'h0050, 32'h0, 0);
        cyc(4'h4, 1, 0, 16'h0050, 32'h0, 0);
        cyc(4'h4, 1, 0, 16'h0050, 32'h0, 0);
        chk("lit_t4_busy_pre", 32'(busy), 32'd1);
        cyc(4'h4, 1, 0, 16'h0050, 32'h0, 0);
        chk("lit_t4_err_vec",  32'(err_vec),  32'h20);
        chk("lit_t4_err_cnt",  32'(err_cnt),  32'd1);
        chk("lit_t4_busy",     32'(busy),     32'd0);
        chk("lit_t4_xfer_cnt", 32'(xfer_cnt), 32'd5);
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        err_clr = 1'b1;
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        err_clr = 1'b0;

        // error counter saturation, then err_clr with a same-cycle rule2
        for (int i = 0; i < CMAX + 1; i++) cyc(4'h0, 1, 0, 16'h0, 32'h0, 0);
        chk("lit_t5_err_sat", 32'(err_cnt), 32'(CMAX));
        chk("lit_t5_err_vec", 32'(err_vec), 32'h40);
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        cyc(4'h2, 0, 0, 16'h0060, 32'h0, 0);
        bus.pslverr = 1'b1;
        cyc(4'h2, 1, 0, 16'h0060, 32'h0, 1);
        bus.pslverr = 1'b0;
        chk("lit_t5_slverr", 32'(slverr_cnt), 32'd1);
        err_clr = 1'b1;
        cyc(4'h0, 1, 0, 16'h0060, 32'h0, 0);
        err_clr = 1'b0;
        chk("lit_t5_clr_vec", 32'(err_vec),      32'h04);
        chk("lit_t5_clr_cnt", 32'(err_cnt),      32'd1);
        chk("lit_t5_clr_id",  32'(first_err_id), 32'd2);
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);

        // checking disabled, then reset in the middle of ACCESS
        preset = 1'b1;
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        preset = 1'b0; chk_en = 1'b0;
        cyc(4'h0, 1, 0, 16'h0, 32'h0, 0);
        cyc(4'h1, 1, 0, 16'h0070, 32'h0, 0);
        cyc(4'h1, 1, 0, 16'h0070, 32'h0, 0);
        chk("lit_t6_busy_mid", 32'(busy),    32'd1);
        chk("lit_t6_err_vec",  32'(err_vec), 32'h0);
        preset = 1'b1;
        cyc(4'h1, 1, 0, 16'h0070, 32'h0, 1);
        preset = 1'b0; chk_en = 1'b1;
        chk("lit_t6_busy",     32'(busy),     32'd0);
        chk("lit_t6_xfer_cnt", 32'(xfer_cnt), 32'd0);
        cyc(4'h0, 0, 0, 16'h0, 32'h0, 0);
        chk("lit_t6_err_cnt",  32'(err_cnt),  32'd0);
        chk("lit_t6_fvalid",   32'(first_err_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
